sipo_deserializer: RTL and testbench

Serial-in, parallel-out receiver that pairs with the team's parallel-load serial-out shift register. It reassembles WIDTH-bit words from a qualified serial bit stream and presents each completed word on a parallel bus with a one-cycle valid strobe. Frame alignment comes from a start qualifier on the first bit. It sits on the receive side of the 1-bit serial link in the top-level datapath.

---
 rtl/sipo_deserializer.sv | 109 ++++++++++
 tb/tb_sipo_deserializer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver. Reassembles WIDTH-bit words from a qualified
// serial stream framed by a start bit, and presents each completed word on po
// with a one-cycle po_valid strobe. An early start aborts the frame in progress.
module sipo_deserializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             si,
  input  logic             si_valid,
  input  logic             start,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  output logic             busy,
  output logic             frame_err
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] OneCnt  = CntW'(1);

  typedef enum logic {StIdle, StRecv} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             po_valid_q, po_valid_d;
  logic             frame_err_q, frame_err_d;

  // Shift one bit into a word in the configured bit order.
  function automatic logic [WIDTH-1:0] insert(input logic [WIDTH-1:0] base, input logic b);
    logic [WIDTH-1:0] res;
    if (MSB_FIRST) begin
      res = {base[WIDTH-2:0], b};
    end else begin
      res = {b, base[WIDTH-1:1]};
    end
    return res;
  endfunction

  // Next-state logic: framing, bit insertion, word completion and abort.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    po_d        = po_q;
    po_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (si_valid && start) begin
          sr_d    = insert('0, si);
          cnt_d   = OneCnt;
          state_d = StRecv;
        end
      end
      StRecv: begin
        if (si_valid) begin
          if (start) begin
            // Early start: drop the partial word and begin a fresh frame.
            frame_err_d = 1'b1;
            sr_d        = insert('0, si);
            cnt_d       = OneCnt;
          end else if (cnt_q == LastCnt) begin
            sr_d       = insert(sr_q, si);
            po_d       = insert(sr_q, si);
            po_valid_d = 1'b1;
            cnt_d      = '0;
            state_d    = StIdle;
          end else begin
            sr_d  = insert(sr_q, si);
            cnt_d = cnt_q + OneCnt;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sr_q        <= '0;
      po_q        <= '0;
      po_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      po_q        <= po_d;
      po_valid_q  <= po_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign po        = po_q;
  assign po_valid  = po_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == StRecv);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench: an MSB-first and an LSB-first instance share one input
// stream; a frame-level reference model predicts every output each cycle.
module tb_sipo_deserializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, si, si_valid, start;
  logic [W-1:0] po_m, po_l;
  logic         pv_m, pv_l, busy_m, busy_l, fe_m, fe_l;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: bits of the frame in progress.
  int           frame_q[$];
  bit           in_frame;
  logic [W-1:0] exp_po_m, exp_po_l;
  bit           exp_pv, exp_fe;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .si(si), .si_valid(si_valid), .start(start),
    .po(po_m), .po_valid(pv_m), .busy(busy_m), .frame_err(fe_m)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .si(si), .si_valid(si_valid), .start(start),
    .po(po_l), .po_valid(pv_l), .busy(busy_l), .frame_err(fe_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    in_frame = 1'b0;
    frame_q.delete();
    exp_po_m = '0;
    exp_po_l = '0;
    exp_pv   = 1'b0;
    exp_fe   = 1'b0;
  endtask

  // One sampling edge of the receiver, described at frame level.
  task automatic model_edge();
    int m, l;
    exp_pv = 1'b0;
    exp_fe = 1'b0;
    if (reset) begin
      model_reset();
    end else if (si_valid) begin
      if (start) begin
        if (in_frame) exp_fe = 1'b1;
        frame_q.delete();
        frame_q.push_back(int'(si));
        in_frame = 1'b1;
      end else if (in_frame) begin
        frame_q.push_back(int'(si));
        if (frame_q.size() == W) begin
          m = 0;
          l = 0;
          foreach (frame_q[i]) begin
            m = m * 2 + frame_q[i];
            l = l + frame_q[i] * (1 << i);
          end
          exp_po_m = W'(m);
          exp_po_l = W'(l);
          exp_pv   = 1'b1;
          in_frame = 1'b0;
          frame_q.delete();
        end
      end
    end
  endtask

  task automatic check_all();
    check("po_msb", 32'(po_m), 32'(exp_po_m));
    check("po_lsb", 32'(po_l), 32'(exp_po_l));
    check("po_valid_msb", 32'(pv_m), 32'(exp_pv));
    check("po_valid_lsb", 32'(pv_l), 32'(exp_pv));
    check("busy_msb", 32'(busy_m), 32'(in_frame));
    check("busy_lsb", 32'(busy_l), 32'(in_frame));
    check("frame_err_msb", 32'(fe_m), 32'(exp_fe));
    check("frame_err_lsb", 32'(fe_l), 32'(exp_fe));
  endtask

  // Drive one cycle of inputs, clock it, then compare just after the edge.
  task automatic step(input logic v, input logic st, input logic b);
    si_valid = v;
    start    = st;
    si       = b;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse landing between clock edges.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    si       = 1'b0;
    si_valid = 1'b0;
    start    = 1'b0;
    model_reset();
    #10;
    check_all();
    check("reset_po", 32'(po_m), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Valid bits without start are ignored in idle.
    repeat (3) step(1'b1, 1'b0, 1'b1);
    check("idle_busy", 32'(busy_m), 32'h0);

    // MSB-first word 1011.
    step(1'b1, 1'b1, 1'b1);
    check("busy_after_first", 32'(busy_m), 32'h1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("msb_word", 32'(po_m), 32'hB);
    check("msb_valid", 32'(pv_m), 32'h1);
    check("lsb_word", 32'(po_l), 32'hD);
    step(1'b0, 1'b0, 1'b0);
    check("valid_one_cycle", 32'(pv_m), 32'h0);

    // Gapped stream 0110 with two idle cycles between bits.
    for (int i = 0; i < W; i++) begin
      step(1'b1, (i == 0), (i == 1 || i == 2));
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0);
    end
    check("gapped_word", 32'(po_m), 32'h6);

    // Back-to-back 1011 then 1100.
    step(1'b1, 1'b1, 1'b1); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("b2b_first", 32'(po_m), 32'hB);
    step(1'b1, 1'b1, 1'b1); step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("b2b_second", 32'(po_m), 32'hC);
    check("b2b_no_err", 32'(fe_m), 32'h0);

    // Early start aborts the first frame.
    step(1'b1, 1'b1, 1'b1); step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("early_start_err", 32'(fe_m), 32'h1);
    check("early_start_po_held", 32'(po_m), 32'hC);
    step(1'b1, 1'b0, 1'b1);
    check("err_one_cycle", 32'(fe_m), 32'h0);
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
    check("early_start_word", 32'(po_m), 32'hC);

    // Reset mid-frame, then LSB-first 1,1,0,1 -> 1011.
    step(1'b1, 1'b1, 1'b1); step(1'b1, 1'b0, 1'b0);
    async_reset();
    check("midreset_busy", 32'(busy_l), 32'h0);
    step(1'b1, 1'b1, 1'b1); step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("lsb_first_word", 32'(po_l), 32'hB);

    // Randomized stream with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        step(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0), 1'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
